// File: rtl/switch_cfg_loader_if.sv
// Bit-serial config stream in, switch-matrix config write bus and status out.
// master: the loader; slave: the stream source / matrix / observer side.
interface switch_cfg_loader_if;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 6;
  localparam int unsigned EW = 2;

  logic          sdi_valid;
  logic          sdi_bit;
  logic          sdi_ready;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [EW-1:0] err_code;

  modport master (
    input  sdi_valid, sdi_bit,
    output sdi_ready, cfg_we, cfg_addr, cfg_data, busy, done, err, err_code
  );

  modport slave (
    output sdi_valid, sdi_bit,
    input  sdi_ready, cfg_we, cfg_addr, cfg_data, busy, done, err, err_code
  );
endinterface

// File: rtl/switch_cfg_loader.sv
// Serial frame loader for the switch-matrix routing registers: sync hunt, entry
// buffering with per-entry and checksum validation, then an all-or-nothing commit.
module switch_cfg_loader #(
  parameter int unsigned NTB  = 5,
  parameter int unsigned NLR  = 4,
  parameter int unsigned CW   = 6,
  parameter logic [7:0]  SYNC = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_cfg_loader_if.master  bus
);
  localparam int unsigned NENT = 2 * NTB + 2 * NLR;
  localparam int unsigned AW   = 5;
  localparam int unsigned BCW  = 3;
  localparam int unsigned EW   = 2;
  localparam logic [2:0]  NTB_L = 3'(NTB);
  localparam logic [2:0]  NLR_L = 3'(NLR);

  typedef enum logic [2:0] {
    S_HUNT, S_LOAD, S_CHECK, S_COMMIT, S_DONE, S_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      sync_q, sync_d;
  logic [CW-1:0]   field_q, field_d;
  logic [BCW-1:0]  bitcnt_q, bitcnt_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   csum_q, csum_d;
  logic [EW-1:0]   sticky_q, sticky_d;
  logic [CW-1:0]   buf_q [NENT];
  logic [CW-1:0]   buf_d [NENT];

  logic            sdi_ready_q, sdi_ready_d;
  logic            cfg_we_q, cfg_we_d;
  logic [AW-1:0]   cfg_addr_q, cfg_addr_d;
  logic [CW-1:0]   cfg_data_q, cfg_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [EW-1:0]   err_code_q, err_code_d;

  logic            accept;
  logic [7:0]      sync_shift;
  logic [CW-1:0]   field_shift;
  logic [2:0]      side;
  logic [2:0]      idx;
  logic [EW-1:0]   entry_code;

  assign accept      = bus.sdi_valid && sdi_ready_q;
  assign sync_shift  = {sync_q[6:0], bus.sdi_bit};
  assign field_shift = {field_q[CW-2:0], bus.sdi_bit};
  assign side        = field_shift[2:0];
  assign idx         = field_shift[5:3];

  // Legality of the entry completing on this bit; side 0 ignores the index.
  always_comb begin
    entry_code = 2'd0;
    if (side >= 3'd5) begin
      entry_code = 2'd1;
    end else if ((side == 3'd1 || side == 3'd3) && idx >= NTB_L) begin
      entry_code = 2'd2;
    end else if ((side == 3'd2 || side == 3'd4) && idx >= NLR_L) begin
      entry_code = 2'd2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_HUNT;
      sync_q   <= '0;
      field_q  <= '0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      csum_q   <= '0;
      sticky_q <= '0;
      for (int i = 0; i < NENT; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      field_q  <= field_d;
      bitcnt_q <= bitcnt_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      csum_q   <= csum_d;
      sticky_q <= sticky_d;
      buf_q    <= buf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sync_d   = sync_q;
    field_d  = field_q;
    bitcnt_d = bitcnt_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    csum_d   = csum_q;
    sticky_d = sticky_q;
    buf_d    = buf_q;
    case (state_q)
      S_HUNT: begin
        if (accept) begin
          sync_d = sync_shift;
          if (sync_shift == SYNC) begin
            state_d  = S_LOAD;
            sync_d   = '0;
            field_d  = '0;
            bitcnt_d = '0;
            cnt_d    = '0;
            acc_d    = '0;
            sticky_d = '0;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          field_d = field_shift;
          if (bitcnt_q == BCW'(CW - 1)) begin
            bitcnt_d = '0;
            // Entry index NENT is the trailing checksum field.
            if (cnt_q == AW'(NENT)) begin
              csum_d  = field_shift;
              state_d = S_CHECK;
            end else begin
              buf_d[cnt_q] = field_shift;
              acc_d        = acc_q ^ field_shift;
              if (sticky_q == 2'd0) sticky_d = entry_code;
              cnt_d        = AW'(cnt_q + AW'(1));
            end
          end else begin
            bitcnt_d = BCW'(bitcnt_q + BCW'(1));
          end
        end
      end
      S_CHECK: begin
        cnt_d   = '0;
        state_d = (sticky_q != 2'd0 || csum_q != acc_q) ? S_ERROR : S_COMMIT;
      end
      S_COMMIT: begin
        if (cnt_q == AW'(NENT - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = AW'(cnt_q + AW'(1));
        end
      end
      S_DONE, S_ERROR: begin
        sync_d  = '0;
        state_d = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned.
  always_comb begin
    sdi_ready_d = (state_d == S_HUNT) || (state_d == S_LOAD);
    busy_d      = (state_d != S_HUNT);
    cfg_we_d    = (state_d == S_COMMIT);
    cfg_addr_d  = cfg_we_d ? cnt_d : '0;
    cfg_data_d  = cfg_we_d ? buf_q[cnt_d] : '0;
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERROR);
    err_code_d  = err_code_q;
    if (state_d == S_ERROR) begin
      err_code_d = (sticky_q != 2'd0) ? sticky_q : 2'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdi_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      sdi_ready_q <= sdi_ready_d;
      busy_q      <= busy_d;
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.sdi_ready = sdi_ready_q;
  assign bus.busy      = busy_q;
  assign bus.cfg_we    = cfg_we_q;
  assign bus.cfg_addr  = cfg_addr_q;
  assign bus.cfg_data  = cfg_data_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_switch_cfg_loader.sv
// Directed frame vectors for switch_cfg_loader with cycle-exact output checks.
module tb_switch_cfg_loader;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [1:0] last_code;

  switch_cfg_loader_if bif ();

  switch_cfg_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ent [18];
    logic [5:0] csum;
    logic [1:0] code;
    int         maxgap;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b, input int maxgap);
    if (maxgap > 0) begin
      repeat ($urandom_range(maxgap, 0)) begin
        @(negedge clk);
        bif.sdi_valid = 1'b0;
        bif.sdi_bit   = 1'($urandom);
      end
    end
    @(negedge clk);
    bif.sdi_valid = 1'b1;
    bif.sdi_bit   = b;
  endtask

  task automatic send_byte(input logic [7:0] v, input int maxgap);
    for (int b = 7; b >= 0; b--) send_bit(v[b], maxgap);
  endtask

  task automatic send_frame(input vec_t v);
    send_byte(8'hA5, v.maxgap);
    for (int k = 0; k < 18; k++)
      for (int b = 5; b >= 0; b--) send_bit(v.ent[k][b], v.maxgap);
    for (int b = 5; b >= 0; b--) send_bit(v.csum[b], v.maxgap);
  endtask

  // Walks the post-frame cycles: CHECK, then commit+done or the error pulse.
  task automatic finish_frame(input vec_t v);
    @(negedge clk);
    bif.sdi_valid = 1'b0;
    chk("check_ready", 32'(bif.sdi_ready), 32'd0);
    chk("check_busy", 32'(bif.busy), 32'd1);
    chk("check_we", 32'(bif.cfg_we), 32'd0);
    if (v.code == 2'd0) begin
      for (int i = 0; i < 18; i++) begin
        @(negedge clk);
        chk("wr_we", 32'(bif.cfg_we), 32'd1);
        chk("wr_addr", 32'(bif.cfg_addr), 32'(i));
        chk("wr_data", 32'(bif.cfg_data), 32'(v.ent[i]));
      end
      @(negedge clk);
      chk("done_pulse", 32'(bif.done), 32'd1);
      chk("done_we", 32'(bif.cfg_we), 32'd0);
      chk("done_err", 32'(bif.err), 32'd0);
      chk("done_addr", 32'(bif.cfg_addr), 32'd0);
    end else begin
      @(negedge clk);
      chk("err_pulse", 32'(bif.err), 32'd1);
      chk("err_code", 32'(bif.err_code), 32'(v.code));
      chk("err_we", 32'(bif.cfg_we), 32'd0);
      chk("err_done", 32'(bif.done), 32'd0);
      last_code = v.code;
    end
    @(negedge clk);
    chk("rearm_ready", 32'(bif.sdi_ready), 32'd1);
    chk("rearm_busy", 32'(bif.busy), 32'd0);
    chk("rearm_done", 32'(bif.done), 32'd0);
    chk("rearm_err", 32'(bif.err), 32'd0);
    chk("hold_code", 32'(bif.err_code), 32'(last_code));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_we", 32'(bif.cfg_we), 32'd0);
    chk("rst_addr", 32'(bif.cfg_addr), 32'd0);
    chk("rst_data", 32'(bif.cfg_data), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_done", 32'(bif.done), 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);
    chk("rst_code", 32'(bif.err_code), 32'd0);
    chk("rst_ready", 32'(bif.sdi_ready), 32'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    last_code = 2'd0;
    rst = 1'b1;
    bif.sdi_valid = 1'b0;
    bif.sdi_bit   = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 18; k++) vecs[v].ent[k] = 6'h00;
      vecs[v].csum   = 6'h00;
      vecs[v].code   = 2'd0;
      vecs[v].maxgap = 0;
    end
    // Good frame with one top-side and one right-side route.
    vecs[1].ent[3] = 6'h12; vecs[1].ent[14] = 6'h21; vecs[1].csum = 6'h33;
    // Side code 5 is illegal.
    vecs[2].ent[7] = 6'h05; vecs[2].csum = 6'h05; vecs[2].code = 2'd1;
    // Side 2 with index 4 exceeds the 4-pin side.
    vecs[3].ent[10] = 6'h22; vecs[3].csum = 6'h22; vecs[3].code = 2'd2;
    // Correct entries, checksum LSB flipped.
    vecs[4].ent[3] = 6'h12; vecs[4].ent[14] = 6'h21; vecs[4].csum = 6'h32; vecs[4].code = 2'd3;
    // Boundary-legal entries with stall gaps.
    vecs[5].ent[0] = 6'h01; vecs[5].ent[4] = 6'h21; vecs[5].ent[17] = 6'h1C;
    vecs[5].csum = 6'h3C; vecs[5].maxgap = 2;

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v]);
      finish_frame(vecs[v]);
    end

    // Only the first error of a frame is reported.
    begin
      vec_t fe;
      fe = vecs[0];
      fe.ent[1] = 6'h2B; fe.ent[9] = 6'h07; fe.csum = 6'h2C; fe.code = 2'd2;
      send_frame(fe);
      finish_frame(fe);
    end

    // Garbage bytes must not lock; then a gapped good frame.
    send_byte(8'h5A, 2);
    send_byte(8'hF0, 2);
    @(negedge clk);
    bif.sdi_valid = 1'b0;
    chk("garbage_busy", 32'(bif.busy), 32'd0);
    chk("garbage_ready", 32'(bif.sdi_ready), 32'd1);
    vecs[1].maxgap = 3;
    send_frame(vecs[1]);
    finish_frame(vecs[1]);

    // Reset during the 9th commit write.
    vecs[1].maxgap = 0;
    send_frame(vecs[1]);
    @(negedge clk);
    bif.sdi_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("pre_rst_addr", 32'(bif.cfg_addr), 32'(i));
    end
    @(negedge clk);
    chk("ninth_we", 32'(bif.cfg_we), 32'd1);
    chk("ninth_addr", 32'(bif.cfg_addr), 32'd8);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    last_code = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(vecs[0]);
    finish_frame(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/switch_cfg_loader.md
Name: switch_cfg_loader

Overview:
- Serial configuration programmer for the 5/5/4/4-pin switch matrix: the writing end of the matrix's per-pin routing-select registers.
- Hunts for a sync byte on a bit-serial stream and buffers 18 six-bit routing entries.
- Validates each entry and a frame checksum.
- Only on a clean frame, writes all entries to the matrix configuration bus, one per cycle.
- Sits between the bitstream source (JTAG/SPI deserialiser) and the switch-matrix config registers.

Parameters:
- NTB, 5, pins per top/bottom side
- NLR, 4, pins per left/right side
- CW, 6, config entry width: [2:0] source side, [5:3] source index
- SYNC, 8'hA5, frame sync byte

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- sdi_valid  in  1  serial bit valid
- sdi_bit  in  1  serial data bit, MSB-first per field
- sdi_ready  out  1  loader accepts a bit this cycle
- cfg_we  out  1  config write strobe
- cfg_addr  out  5  entry address: 0-4 top, 5-9 bottom, 10-13 left, 14-17 right
- cfg_data  out  6  entry value
- busy  out  1  frame in progress (any state other than HUNT)
- done  out  1  one-cycle pulse after the last write of a good frame
- err  out  1  one-cycle pulse on a rejected frame
- err_code  out  2  0 none, 1 bad side code, 2 index out of range, 3 checksum; holds until the next err or reset

Behaviour:
- A bit is accepted when sdi_valid && sdi_ready.
- Frame format: SYNC (8 bits), then 18 entries × 6 bits in address order, then 6-bit checksum = XOR of all 18 entries.
- Reset (async, any state, including mid-commit): state HUNT; sync shifter, bit/entry counters, buffer, sticky error and checksum accumulator cleared.
  - Outputs: cfg_we=0, cfg_addr=0, cfg_data=0, busy=0, done=0, err=0, err_code=0, sdi_ready=1.
  - Entries already written in an interrupted commit stay in the matrix; there is no rollback.
- States:
  - HUNT: sdi_ready=1. 8-bit shift register of accepted bits. When the shifter value including the current bit equals SYNC, go to LOAD next cycle. Overlapping sync search is allowed.
  - LOAD: sdi_ready=1, busy=1. Accepts 108 entry bits and then 6 checksum bits. On each completed entry:
    - store it in buffer[k];
    - XOR it into the accumulator;
    - check the side code: 0 (unconnected) and 1-4 are legal; 5-7 set sticky error code 1;
    - check the index: for side 1 or 3, index must be <NTB; for side 2 or 4, index must be <NLR; otherwise sticky code 2. Side 0 ignores the index.
    - Only the first error is kept. Loading continues to the end of the frame regardless.
    - When the 6th checksum bit is accepted, go to CHECK.
  - CHECK: one cycle, sdi_ready=0. If the sticky error is set, use that code; else if the received checksum != accumulator, code 3. Error goes to ERROR, otherwise to COMMIT.
  - COMMIT: sdi_ready=0. 18 consecutive cycles with cfg_we=1, cfg_addr=0..17 ascending, cfg_data=buffer[addr]. Then go to DONE.
  - DONE: one cycle: done=1, cfg_we=0, sdi_ready=0. Then go to HUNT.
  - ERROR: one cycle: err=1, err_code updated, no writes, sdi_ready=0. Then go to HUNT.
- Latency: if the last checksum bit is accepted in cycle N:
  - CHECK is cycle N+1;
  - first write is N+2, last write N+19;
  - done (or err) is N+20 (err at N+2 on the error path);
  - HUNT again with sdi_ready=1 at N+21 (N+3 on the error path).
- Gaps: sdi_valid=0 gaps anywhere in HUNT/LOAD simply stall; there is no timeout.
- Sync re-arm: the sync shifter is cleared on entering HUNT, so a new frame needs a full SYNC.
- cfg_addr/cfg_data: registered, valid only while cfg_we=1; outside COMMIT they drive 0.

Test Plan:
- Good frame, all entries 6'b000000, checksum 0 -> 18 writes, addr 0..17, data 0; done at N+20; err stays 0.
- Frame with entry 3 = 6'b010_010 (right[2]) and entry 14 = 6'b100_001 (top[4]), checksum 6'b110_011 -> writes with data 0x12 at addr 3 and 0x21 at addr 14, 0 elsewhere; done pulse.
- Entry 7 = 6'b000_101 -> no cfg_we ever asserted; err pulse; err_code=1. Entry 10 = 6'b100_010 (right[4]) -> err_code=2.
- Correct entries, checksum bit flipped -> err_code=3 at N+2; sdi_ready returns to 1 at N+3.
- Stream garbage 0x5A,0xF0, then 0xA5, with random sdi_valid gaps -> lock only after 0xA5; frame loads correctly; done pulse.
- Assert rst at the 9th write cycle -> cfg_we drops immediately; all outputs 0; busy=0; next good frame loads normally.
